button_debouncer: RTL and testbench

//  Conditions one raw, active-low, bouncy push-button input (pmod pin) into clean

---
 rtl/button_debouncer_if.sv | 10 +
 rtl/button_debouncer.sv | 96 +++++++++
 tb/tb_button_debouncer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw active-low pin in, clean level and strobes out.
interface button_debouncer_if;
  logic btn_n;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;

  modport master (input btn_n, output btn_level, press_pulse, release_pulse);
  modport slave  (output btn_n, input btn_level, press_pulse, release_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a bouncy active-low push button and debounces it with a stability
// timer, producing a clean level plus single-cycle press/release strobes.
module button_debouncer #(
  parameter int STABLE_CYCLES = 120000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk,
  input  logic                rst,
  button_debouncer_if.master  bif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic               btn_s;
  logic               level_q, press_q, release_q;

  // Sync flops reset to the released level so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '1;
    else      sync <= {sync[SYNC_STAGES-2:0], bif.btn_n};
  end

  assign btn_s = ~sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= CHK_PRESS;
            cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state   <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= CHK_RELEASE;
            cnt   <= '0;
          end
        end
        CHK_RELEASE: begin
          if (btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign bif.btn_level     = level_q;
  assign bif.press_pulse   = press_q;
  assign bif.release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  int   press_cnt = 0, rel_cnt = 0, both_cnt = 0, dbl_cnt = 0;
  int   last_press_cyc = -1, last_rel_cyc = -1;
  logic level_at_press = 1'b0, level_at_rel = 1'b1;
  logic prev_press = 1'b0, prev_rel = 1'b0;
  logic [3:0] cnt4;

  button_debouncer_if bif();

  button_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream LED counter model fed by press_pulse.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt4 <= 4'd0;
    else if (bif.press_pulse) cnt4 <= cnt4 + 4'd1;
  end

  always @(negedge clk) begin
    if (bif.press_pulse) begin
      press_cnt++;
      last_press_cyc = cyc;
      level_at_press = bif.btn_level;
    end
    if (bif.release_pulse) begin
      rel_cnt++;
      last_rel_cyc = cyc;
      level_at_rel = bif.btn_level;
    end
    if (bif.press_pulse && bif.release_pulse) both_cnt++;
    if ((bif.press_pulse && prev_press) || (bif.release_pulse && prev_rel)) dbl_cnt++;
    prev_press = bif.press_pulse;
    prev_rel   = bif.release_pulse;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int c0, p0, r0;
    bif.btn_n = 1'b1;

    // Reset state
    step(3);
    chk("rst_level", bif.btn_level, 0);
    chk("rst_press", bif.press_pulse, 0);
    chk("rst_release", bif.release_pulse, 0);

    // Reset release with btn released: nothing happens
    rst = 1'b1;
    step(5);
    chk("rel_hi_nopulse", press_cnt + rel_cnt, 0);

    // Clean press
    c0 = cyc; bif.btn_n = 1'b0;
    step(20);
    chk("press_cnt", press_cnt, 1);
    chk("press_latency", last_press_cyc, c0 + 7);
    chk("press_level_same", level_at_press, 1);
    chk("press_level_hold", bif.btn_level, 1);

    // Clean release
    c0 = cyc; bif.btn_n = 1'b1;
    step(20);
    chk("rel_cnt", rel_cnt, 1);
    chk("rel_latency", last_rel_cyc, c0 + 7);
    chk("rel_level_same", level_at_rel, 0);
    chk("rel_level_hold", bif.btn_level, 0);

    // Bounce every 2 cycles rejected
    p0 = press_cnt;
    for (int i = 0; i < 4; i++) begin
      bif.btn_n = 1'b0; step(2);
      bif.btn_n = 1'b1; step(2);
    end
    step(10);
    chk("bounce_nopulse", press_cnt - p0, 0);
    chk("bounce_level", bif.btn_level, 0);

    // Press again, then 3-cycle glitch during release check
    bif.btn_n = 1'b0; step(15);
    chk("press2_level", bif.btn_level, 1);
    r0 = rel_cnt;
    bif.btn_n = 1'b1; step(3);
    bif.btn_n = 1'b0; step(15);
    chk("glitch_norel", rel_cnt - r0, 0);
    chk("glitch_level", bif.btn_level, 1);

    // Reset while pressed clears level asynchronously
    @(negedge clk); #2 rst = 1'b0; #1;
    chk("async_rst_level", bif.btn_level, 0);
    step(1);
    bif.btn_n = 1'b1; rst = 1'b1;
    step(10);

    // Reset at cnt=2 of CHK_PRESS, release with btn still held
    p0 = press_cnt;
    c0 = cyc; bif.btn_n = 1'b0;
    step(5);
    #2 rst = 1'b0; #1;
    chk("midchk_level", bif.btn_level, 0);
    chk("midchk_press", bif.press_pulse, 0);
    step(2);
    rst = 1'b1; c0 = cyc;
    step(5);
    chk("rel_lo_nopulse", press_cnt - p0, 0);
    step(3);
    chk("rel_lo_press", press_cnt - p0, 1);
    chk("rel_lo_latency", last_press_cyc, c0 + 7);

    // Ten press/release pairs from a fresh reset
    bif.btn_n = 1'b1; step(12);
    rst = 1'b0; step(2); rst = 1'b1; step(2);
    p0 = press_cnt; r0 = rel_cnt;
    for (int i = 0; i < 10; i++) begin
      bif.btn_n = 1'b0; step(10);
      bif.btn_n = 1'b1; step(10);
    end
    step(5);
    chk("pairs_press", press_cnt - p0, 10);
    chk("pairs_release", rel_cnt - r0, 10);
    chk("pairs_cnt4", cnt4, 10);

    chk("never_both", both_cnt, 0);
    chk("single_cycle", dbl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
